// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bundle: redirect, instruction-memory read port and decode handshake.
// master = fetch_queue side, slave = memory/decode/branch environment.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
  logic [CW-1:0] count;

  modport master (
    input  redirect, redirect_pc, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, count
  );

  modport slave (
    output redirect, redirect_pc, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch PC + DEPTH-entry instruction queue; first inst_valid 2 cycles after issue, 1/cycle sustained.
// Requests are credit-limited by (count + inflight) so the queue never overflows; redirect flushes.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_inflight_pc;
  logic          r_inflight;
  logic          r_kill;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_q_inst [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];

  logic [CW:0]   w_credit;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;

  // Credit uses registered state only, keeping inst_ready off the imem_req path.
  assign w_credit = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue  = !rst && !bus.redirect && (w_credit < (CW+1)'(DEPTH));
  assign w_push   = r_inflight && !r_kill && !bus.redirect && (r_count < CW'(DEPTH));
  assign w_pop    = (r_count != '0) && bus.inst_ready && !bus.redirect;

  assign bus.imem_req   = w_issue;
  assign bus.imem_addr  = r_fetch_pc;
  assign bus.inst_valid = (r_count != '0);
  assign bus.inst       = r_q_inst[r_rd_ptr];
  assign bus.inst_pc    = r_q_pc[r_rd_ptr];
  assign bus.count      = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_kill        <= 1'b0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_inst[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else begin
      r_kill <= bus.redirect && r_inflight;
      if (bus.redirect) begin
        r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        r_inflight <= 1'b0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_issue) begin
          r_fetch_pc    <= r_fetch_pc + 32'd4;
          r_inflight_pc <= r_fetch_pc;
          r_inflight    <= 1'b1;
        end else begin
          r_inflight <= 1'b0;
        end
        if (w_push) begin
          r_q_inst[r_wr_ptr] <= bus.imem_rdata;
          r_q_pc[r_wr_ptr]   <= r_inflight_pc;
          r_wr_ptr           <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a transaction model predicts requests and the instruction stream.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  ent_t        sb[$];
  logic        m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_pc;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word i holds 0x13 + i.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= 32'h0000_0013 + (bus.imem_addr >> 2);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge: assert rst, check outputs in the same cycle, release at next negedge.
  task automatic do_reset();
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.inst_ready = 1'b0;
    #1;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_vld", bus.inst_valid, 1'b0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_pc", bus.inst_pc, 32'h0);
    chk("rst_cnt", bus.count, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_infl = 1'b0;
    m_pc = 32'h0;
  endtask

  // One clock cycle: drive inputs at the negedge, check outputs, advance the model.
  task automatic cycle(input logic rd, input logic [31:0] rpc, input logic rdy);
    logic exp_req;
    int   occ;
    bus.redirect = rd;
    bus.redirect_pc = rpc;
    bus.inst_ready = rdy;
    #1;
    occ = sb.size();
    exp_req = !rd && ((occ + (m_infl ? 1 : 0)) < DEPTH);
    chk("req", bus.imem_req, exp_req);
    chk("addr", bus.imem_addr, m_pc);
    chk("cnt", bus.count, occ);
    chk("vld", bus.inst_valid, occ != 0);
    if (occ != 0) begin
      chk("inst_pc", bus.inst_pc, sb[0].pc);
      chk("inst", bus.inst, sb[0].data);
    end
    if (rd) begin
      sb.delete();
      m_infl = 1'b0;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (occ != 0 && rdy) void'(sb.pop_front());
      if (m_infl) sb.push_back('{m_infl_pc, 32'h0000_0013 + (m_infl_pc >> 2)});
      if (exp_req) begin
        m_infl_pc = m_pc;
        m_pc = m_pc + 32'd4;
        m_infl = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.inst_ready = 1'b0;
    sb.delete();
    m_infl = 1'b0;
    m_pc = 32'h0;
    @(negedge clk);

    // Free run with decode always ready.
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 1'b1);

    // Decode stalled: queue saturates, then drains in order.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0);
    chk("sat_cnt", bus.count, DEPTH);
    chk("sat_req", bus.imem_req, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1);

    // Redirect with 3 queued entries and one request in flight.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);
    chk("pre_rd_cnt", bus.count, 32'd3);
    cycle(1'b1, 32'h0000_0103, 1'b0);
    chk("rd_cnt0", bus.count, 32'h0);
    chk("rd_addr", bus.imem_addr, 32'h0000_0100);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("rd_vld_n3", bus.inst_valid, 1'b1);
    chk("rd_pc_n3", bus.inst_pc, 32'h0000_0100);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

    // Redirect coinciding with a valid handshake.
    chk("hs_vld", bus.inst_valid, 1'b1);
    cycle(1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);

    // Back-to-back redirects, last one wins.
    cycle(1'b1, 32'h0000_0300, 1'b1);
    cycle(1'b1, 32'h0000_0400, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

    // Address wrap at the top of the 32-bit space.
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);

    // Random decode backpressure.
    for (int i = 0; i < 40; i++) cycle(1'b0, 32'h0, 1'($urandom_range(0, 1)));

    // Reset in the middle of a full queue.
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0);
    chk("full_cnt", bus.count, DEPTH);
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
